mem_req_arbiter: RTL and testbench

//   Two-port round-robin arbiter between I-cache (port 0) and D-cache (port 1) for the single DDR2

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_req_arbiter_rr_pick.sv | 23 ++
 rtl/mem_req_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants for the I-cache/D-cache DDR2 line arbiter: FSM encoding, port IDs, default widths.
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 31;
    localparam int unsigned DEF_LINE_WIDTH = 256;

    localparam logic PORT_IC = 1'b0;
    localparam logic PORT_DC = 1'b1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_GRANT    = 3'd1;
    localparam logic [2:0] ST_WR       = 3'd2;
    localparam logic [2:0] ST_RD_ISSUE = 3'd3;
    localparam logic [2:0] ST_RD_WAIT  = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

endpackage

// File: rtl/mem_req_arbiter_rr_pick.sv
// 2-way round-robin pick: a lone requester wins, a tie goes to the port that did not win last.
// Latency: combinational. Backpressure: none, the caller decides when to act on the pick.
// Ready/valid: gnt_vld is simply "any request present".
module rr_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       gnt_vld,
    output logic       gnt_id
);

    always_comb begin
        gnt_vld = |req;
        gnt_id  = PORT_IC;
        case (req)
            2'b10:   gnt_id = PORT_DC;
            2'b11:   gnt_id = ~last_gnt;
            default: gnt_id = PORT_IC;
        endcase
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter serialising I-cache (port 0) and D-cache (port 1) line transfers to DDR2.
// Latency: req -> strobe 2 cycles min, done 1 cycle after controller response; one transfer in flight.
// Backpressure: strobes hold until mc_wr_rdy / mc_rd_rdy+mc_rd_valid; MEM_ARB_TIMEOUT_EN adds a watchdog.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned LINE_WIDTH     = DEF_LINE_WIDTH
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [LINE_WIDTH-1:0] p0_wdata,
    output logic                  p0_done,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [LINE_WIDTH-1:0] p1_wdata,
    output logic                  p1_done,
    output logic [LINE_WIDTH-1:0] rdata,
    output logic                  err,
    output logic                  data_wren,
    output logic                  data_rden,
    output logic [ADDR_WIDTH-1:0] data_addr,
    output logic [LINE_WIDTH-1:0] data_wr,
    input  logic                  mc_wr_rdy,
    input  logic                  mc_rd_rdy,
    input  logic                  mc_rd_valid,
    input  logic [LINE_WIDTH-1:0] data_rd
);

    logic [2:0]            state_q, state_d;
    logic                  last_gnt_q, last_gnt_d;
    logic                  id_q, id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wr_q, wr_d;
    logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
    logic                  wren_q, wren_d;
    logic                  rden_q, rden_d;
    logic [1:0]            done_q, done_d;
    logic                  err_q, err_d;
    logic                  sel_we;
    logic                  gnt_vld, gnt_id;
    logic                  tmo_hit;

    rr_pick u_rr_pick (
        .req      ({p1_req, p0_req}),
        .last_gnt (last_gnt_q),
        .gnt_vld  (gnt_vld),
        .gnt_id   (gnt_id)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        busy;

    assign busy = (state_q == ST_WR) || (state_q == ST_RD_ISSUE) || (state_q == ST_RD_WAIT);

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == ST_GRANT) begin
            tmo_cnt_d = '0;
        end else if (busy) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
    end

    // Fires on the TIMEOUT_CYCLES-th busy cycle; a response in that same cycle still wins.
    assign tmo_hit = busy && (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        id_d       = id_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        rdata_d    = rdata_q;
        wren_d     = wren_q;
        rden_d     = rden_q;
        done_d     = '0;
        err_d      = 1'b0;
        sel_we     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    id_d    = gnt_id;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                last_gnt_d = id_q;
                sel_we     = (id_q == PORT_DC) ? p1_we    : p0_we;
                addr_d     = (id_q == PORT_DC) ? p1_addr  : p0_addr;
                wr_d       = (id_q == PORT_DC) ? p1_wdata : p0_wdata;
                if (sel_we) begin
                    wren_d  = 1'b1;
                    state_d = ST_WR;
                end else begin
                    state_d = ST_RD_ISSUE;
                end
            end
            ST_WR: begin
                if (mc_wr_rdy || tmo_hit) begin
                    wren_d       = 1'b0;
                    done_d[id_q] = 1'b1;
                    err_d        = ~mc_wr_rdy;
                    state_d      = ST_DONE;
                end
            end
            ST_RD_ISSUE: begin
                if (mc_rd_rdy) begin
                    rden_d  = 1'b1;
                    state_d = ST_RD_WAIT;
                end else if (tmo_hit) begin
                    done_d[id_q] = 1'b1;
                    err_d        = 1'b1;
                    state_d      = ST_DONE;
                end
            end
            ST_RD_WAIT: begin
                if (mc_rd_valid || tmo_hit) begin
                    rden_d       = 1'b0;
                    done_d[id_q] = 1'b1;
                    err_d        = ~mc_rd_valid;
                    if (mc_rd_valid) begin
                        rdata_d = data_rd;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= PORT_DC;
            id_q       <= PORT_IC;
            addr_q     <= '0;
            wr_q       <= '0;
            rdata_q    <= '0;
            wren_q     <= 1'b0;
            rden_q     <= 1'b0;
            done_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            id_q       <= id_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            rdata_q    <= rdata_d;
            wren_q     <= wren_d;
            rden_q     <= rden_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign p0_done   = done_q[0];
    assign p1_done   = done_q[1];
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign data_wren = wren_q;
    assign data_rden = rden_q;
    assign data_addr = addr_q;
    assign data_wr   = wr_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomised bench for mem_req_arbiter: bench acts as both caches and the memory controller,
// predicting grants, strobe lengths and returned lines from the arbitration rules.
`timescale 1ns/1ps
module tb_mem_req_arbiter;

    localparam int AW = 31;
    localparam int LW = 256;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int T5_HOLD = 12;
`else
    localparam int T5_HOLD = 20;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [LW-1:0] p0_wdata, p1_wdata;
    logic          p0_done, p1_done, err, data_wren, data_rden;
    logic [LW-1:0] rdata, data_wr, data_rd;
    logic [AW-1:0] data_addr;
    logic          mc_wr_rdy, mc_rd_rdy, mc_rd_valid;

    always #5 clk = ~clk;

    mem_req_arbiter #(
        .ADDR_WIDTH (AW),
        .LINE_WIDTH (LW)
`ifdef MEM_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (16)
`endif
    ) dut (
        .clk, .rst_n,
        .p0_req, .p0_we, .p0_addr, .p0_wdata, .p0_done,
        .p1_req, .p1_we, .p1_addr, .p1_wdata, .p1_done,
        .rdata, .err, .data_wren, .data_rden, .data_addr, .data_wr,
        .mc_wr_rdy, .mc_rd_rdy, .mc_rd_valid, .data_rd
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who won last, the line the requesters expect back, and each port's request.
    int            m_last  = 1;
    logic [LW-1:0] m_rdata = '0;
    logic          req_we   [2];
    logic [AW-1:0] req_addr [2];
    logic [LW-1:0] req_wdata[2];

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom();
        return l;
    endfunction

    task automatic raise(input int port, input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] wdata);
        req_we[port] = we; req_addr[port] = addr; req_wdata[port] = wdata;
        if (port == 0) begin p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata; end
        else           begin p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata; end
    endtask

    task automatic drop_and_scramble(input int port);
        if (port == 0) begin p0_req = 1'b0; p0_addr = AW'($urandom()); p0_wdata = rand_line(); end
        else           begin p1_req = 1'b0; p1_addr = AW'($urandom()); p1_wdata = rand_line(); end
    endtask

    function automatic int exp_winner();
        if (p0_req && p1_req) return 1 - m_last;
        return p0_req ? 0 : 1;
    endfunction

    // Runs one transaction as the memory controller; called with the arbiter in IDLE or DONE.
    task automatic service(input logic [LW-1:0] line, input int wr_dly, input int rdy_hold,
                           input int vld_dly, input bit noise, input bit drop_mid,
                           output int winner, output int first_stb, output int rdy_on);
        int wcnt, rcnt, cyc, addr_bad, overlap;
        bit seen;
        logic [1:0] dv;
        logic e, stb_at_done;
        logic [LW-1:0] rd;
        winner = exp_winner();
        wcnt = 0; rcnt = 0; cyc = 0; addr_bad = 0; overlap = 0; seen = 0;
        first_stb = -1; rdy_on = -1; dv = '0; e = 1'b0; rd = '0; stb_at_done = 1'b0;
        while (!seen && cyc < 400) begin
            if (cyc > 0 && (p0_done || p1_done)) begin
                seen = 1; dv = {p1_done, p0_done}; e = err; rd = rdata;
                stb_at_done = data_wren | data_rden;
            end else begin
                if (data_wren && data_rden) overlap++;
                if (data_wren || data_rden) begin
                    if (first_stb < 0) first_stb = cyc;
                    if (data_addr !== req_addr[winner]) addr_bad++;
                    if (data_wren && data_wr !== req_wdata[winner]) addr_bad++;
                    if (drop_mid) drop_and_scramble(winner);
                end
                if (data_wren) begin
                    wcnt++;
                    mc_wr_rdy = (wcnt == wr_dly);
                end else begin
                    mc_wr_rdy = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                end
                mc_rd_rdy = (cyc >= rdy_hold);
                if (mc_rd_rdy && rdy_on < 0) rdy_on = cyc;
                if (data_rden) begin
                    rcnt++;
                    mc_rd_valid = (rcnt == vld_dly);
                    data_rd     = mc_rd_valid ? line : rand_line();
                end else begin
                    mc_rd_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                    data_rd     = rand_line();
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        mc_wr_rdy = 1'b0; mc_rd_rdy = 1'b0; mc_rd_valid = 1'b0;
        chk("done_seen", LW'(seen), LW'(1));
        chk("done_port", LW'(dv), (winner == 1) ? LW'(2) : LW'(1));
        chk("err_clear", LW'(e), LW'(0));
        chk("strobes_at_done", LW'(stb_at_done), LW'(0));
        chk("latched_addr_data", LW'(addr_bad), LW'(0));
        chk("strobe_overlap", LW'(overlap), LW'(0));
        if (req_we[winner]) begin
            chk("wren_cycles", LW'(wcnt), LW'(wr_dly));
            chk("rden_cycles_on_wr", LW'(rcnt), LW'(0));
        end else begin
            chk("rden_cycles", LW'(rcnt), LW'(vld_dly));
            chk("wren_cycles_on_rd", LW'(wcnt), LW'(0));
            m_rdata = line;
        end
        chk("rdata", rd, m_rdata);
        m_last = winner;
    endtask

    initial begin
        int w, fs, ro, prev, cyc, wcnt;
        logic [LW-1:0] line;
        rst_n = 1'b0;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        mc_wr_rdy = 0; mc_rd_rdy = 0; mc_rd_valid = 0; data_rd = '0;
        req_we[0] = 0; req_we[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctl", LW'({p0_done, p1_done, err, data_wren, data_rden}), LW'(0));
        chk("reset_addr", LW'(data_addr), LW'(0));
        chk("reset_wr", data_wr, LW'(0));
        chk("reset_rdata", rdata, LW'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // D-cache write, controller accepts on the 5th strobe cycle
        line = {32{8'hA5}};
        raise(1, 1'b1, AW'(32'h100), line);
        service(rand_line(), 5, 0, 1, 1'b0, 1'b0, w, fs, ro);
        chk("t2_strobe_latency", LW'(fs), LW'(2));
        p1_req = 1'b0;

        // I-cache read
        line = {8{32'hDEADBEEF}};
        raise(0, 1'b0, AW'(32'h40), '0);
        service(line, 1, 0, 3, 1'b0, 1'b0, w, fs, ro);
        chk("t3_rdata", rdata, line);
        p0_req = 1'b0;

        // Controller address FIFO full for a while
        raise(0, 1'b0, AW'($urandom()), '0);
        service(rand_line(), 1, T5_HOLD, 2, 1'b0, 1'b0, w, fs, ro);
        chk("t5_rdy_cycle", LW'(ro), LW'(T5_HOLD));
        chk("t5_rden_after_rdy", LW'(fs), LW'(ro + 1));
        p0_req = 1'b0;

`ifdef MEM_ARB_TIMEOUT_EN
        @(posedge clk); #1;
        raise(1, 1'b1, AW'($urandom()), rand_line());
        cyc = 0; wcnt = 0;
        while (!(p0_done || p1_done) && cyc < 100) begin
            if (data_wren) wcnt++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("t6_done_port", LW'({p1_done, p0_done}), LW'(2));
        chk("t6_err", LW'(err), LW'(1));
        chk("t6_wren_cycles", LW'(wcnt), LW'(16));
        chk("t6_strobes_low", LW'({data_wren, data_rden}), LW'(0));
        chk("t6_rdata_kept", rdata, m_rdata);
        m_last = 1;
        p1_req = 1'b0;
`endif

        // Both caches hammering: grants must alternate
        raise(0, 1'($urandom_range(0, 1)), AW'($urandom()), rand_line());
        raise(1, 1'($urandom_range(0, 1)), AW'($urandom()), rand_line());
        prev = m_last;
        for (int i = 0; i < 6; i++) begin
            service(rand_line(), 1 + int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                    1 + int'($urandom_range(0, 3)), 1'b1, 1'b0, w, fs, ro);
            chk("t4_alternate", LW'(w), LW'(1 - prev));
            prev = w;
            raise(w, 1'($urandom_range(0, 1)), AW'($urandom()), rand_line());
        end
        p0_req = 1'b0; p1_req = 1'b0;

        // Random traffic with spurious controller handshakes and mid-transfer request drops
        for (int i = 0; i < 50; i++) begin
            if (!p0_req && $urandom_range(0, 1) == 1)
                raise(0, 1'($urandom_range(0, 1)), AW'($urandom()), rand_line());
            if (!p1_req && $urandom_range(0, 1) == 1)
                raise(1, 1'($urandom_range(0, 1)), AW'($urandom()), rand_line());
            if (!p0_req && !p1_req)
                raise(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom()), rand_line());
            service(rand_line(), 1 + int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                    1 + int'($urandom_range(0, 5)), 1'b1, ($urandom_range(0, 3) == 0), w, fs, ro);
            if (w == 0) p0_req = 1'b0; else p1_req = 1'b0;
        end
        p0_req = 1'b0; p1_req = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset while a read is outstanding
        mc_rd_rdy = 1'b1;
        raise(0, 1'b0, AW'($urandom()), '0);
        fs = 0;
        while (!data_rden && fs < 50) begin
            @(posedge clk); #1;
            fs++;
        end
        chk("t1_in_rd_wait", LW'(data_rden), LW'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("t1_rst_ctl", LW'({p0_done, p1_done, err, data_wren, data_rden}), LW'(0));
        chk("t1_rst_addr", LW'(data_addr), LW'(0));
        chk("t1_rst_rdata", rdata, LW'(0));
        mc_rd_rdy = 1'b0;
        @(posedge clk); #1;
        p0_req = 1'b0; p1_req = 1'b0;
        rst_n = 1'b1;
        m_last = 1; m_rdata = '0;
        @(posedge clk); #1;
        raise(0, 1'($urandom_range(0, 1)), AW'($urandom()), rand_line());
        raise(1, 1'($urandom_range(0, 1)), AW'($urandom()), rand_line());
        service(rand_line(), 2, 0, 2, 1'b0, 1'b0, w, fs, ro);
        chk("t1_tie_goes_p0", LW'(w), LW'(0));
        p0_req = 1'b0; p1_req = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
